// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the UART byte receiver.
// - Default line parameters (baud, oversample, FIFO depth) for uart_byte_rx.
// - Receiver state encodings (3-bit).
// - 2-of-3 majority helper used by the bit voter.
package uart_byte_rx_pkg;

  localparam int UART_CLK_HZ     = 100_000_000;
  localparam int UART_BAUD       = 115_200;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [2:0] {
    UART_IDLE  = 3'd0,
    UART_START = 3'd1,
    UART_DATA  = 3'd2,
    UART_STOP  = 3'd3,
    UART_BREAK = 3'd4
  } uart_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_byte_rx_byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through FIFO.
// - head holds the oldest entry from a register; it is meaningful while empty=0.
// - A push while full is accepted only if a pop happens in the same cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, push_data write request and data
//   pop             remove head (ignored when empty)
//   head            registered head-of-FIFO data
//   full, empty     occupancy flags
//   count           current occupancy, 0..DEPTH
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_next;
  logic             push_ok;
  logic             pop_ok;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ok    = push && (!full || pop);
  assign pop_ok     = pop && !empty;
  assign rd_ptr_inc = rd_ptr + AW'(1);
  assign head       = head_q;
  assign count      = count_q;

  // NOTE: storage array is deliberately left out of reset; only pointers and
  // count define what is valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Next head: a push into an empty (or emptying) FIFO falls straight through,
  // otherwise a pop exposes the following entry.
  // NOTE: default assignment first so no path leaves head_next unassigned
  // (which would infer a latch).
  always_comb begin
    head_next = head_q;
    if (push_ok && (empty || (pop_ok && count_q == CW'(1)))) begin
      head_next = push_data;
    end else if (pop_ok && count_q > CW'(1)) begin
      head_next = mem[rd_ptr_inc];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      head_q <= head_next;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr_inc;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: oversampled 8N1 UART receiver with byte FIFO.
// - rx is double-flopped; all decisions use the synchronised rx_s.
// - Tick generator divides clk down to BAUD*OVERSAMPLE.
// - Each bit is decided by a 2-of-3 vote around mid-bit.
// - Received bytes queue in a FWFT FIFO drained over valid/ready.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   rx           asynchronous serial line, idle high
//   byte_data    head-of-FIFO byte, valid while byte_valid=1
//   byte_valid   FIFO non-empty
//   byte_ready   consumer takes byte_data this cycle
//   fifo_count   FIFO occupancy
//   frame_err    one-cycle pulse: stop bit sampled low
//   overflow     one-cycle pulse: byte dropped because FIFO full
//   busy         receiver is mid-frame
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_HZ     = UART_CLK_HZ,
  parameter int BAUD       = UART_BAUD,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx,
  output logic [7:0]                   byte_data,
  output logic                         byte_valid,
  input  logic                         byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         frame_err,
  output logic                         overflow,
  output logic                         busy
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int MID   = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0]  SC_VOTE0 = SC_W'(MID - 1);
  localparam logic [SC_W-1:0]  SC_VOTE1 = SC_W'(MID);
  localparam logic [SC_W-1:0]  SC_DEC   = SC_W'(MID + 1);

  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             armed;
  uart_state_t      state;
  logic [SC_W-1:0]  sc;
  logic [2:0]       bit_idx;
  logic             vote_a;
  logic             vote_b;
  logic             maj;
  logic             decide;
  logic [7:0]       shreg;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  // Two-flop synchroniser, reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           div_cnt <= '0;
    else if (tick)       div_cnt <= '0;
    else                 div_cnt <= div_cnt + DIV_W'(1);
  end
  assign tick = (div_cnt == DIV_LAST);

  // armed stays low until the line has been seen idle, so a line held low
  // across reset is not mistaken for a start bit.
  always_ff @(posedge clk) begin
    if (reset)              armed <= 1'b0;
    else if (tick && rx_s)  armed <= 1'b1;
  end

  // Third vote is the live sample at the decision tick.
  assign decide = (sc == SC_DEC);
  assign maj    = majority3(vote_a, vote_b, rx_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UART_IDLE;
      sc        <= '0;
      bit_idx   <= '0;
      vote_a    <= 1'b0;
      vote_b    <= 1'b0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (tick) begin
        if (state == UART_START || state == UART_DATA || state == UART_STOP) begin
          if (sc == SC_VOTE0) vote_a <= rx_s;
          if (sc == SC_VOTE1) vote_b <= rx_s;
          sc <= (sc == SC_LAST) ? '0 : sc + SC_W'(1);
        end
        case (state)
          UART_IDLE: begin
            if (armed && !rx_s) begin
              state <= UART_START;
              sc    <= '0;
            end
          end
          UART_START: begin
            if (decide && maj) begin
              state <= UART_IDLE;
            end else if (sc == SC_LAST) begin
              state   <= UART_DATA;
              bit_idx <= '0;
            end
          end
          UART_DATA: begin
            if (decide) shreg <= {maj, shreg[7:1]};
            if (sc == SC_LAST) begin
              if (bit_idx == 3'd7) state <= UART_STOP;
              else                 bit_idx <= bit_idx + 3'd1;
            end
          end
          UART_STOP: begin
            // Leave at mid stop bit so a following start edge is never missed.
            if (decide) begin
              if (maj) begin
                state <= UART_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= UART_BREAK;
              end
            end
          end
          UART_BREAK: begin
            if (rx_s) state <= UART_IDLE;
          end
          default: state <= UART_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != UART_IDLE);
  assign push = tick && (state == UART_STOP) && decide && maj;
  assign pop  = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (reset) overflow <= 1'b0;
    else       overflow <= push && fifo_full && !pop;
  end

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (byte_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign byte_valid = !fifo_empty;

endmodule
